// File: rtl/hc_dff_bank_if.sv
// Pin-side bundle of the flip-flop bank: pin clocks, data, preset/clear and outputs.
interface hc_dff_bank_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 1
);
  logic [CHANNELS-1:0]       cp;
  logic [CHANNELS*WIDTH-1:0] d;
  logic [CHANNELS-1:0]       set_n;
  logic [CHANNELS-1:0]       clr_n;
  logic [CHANNELS*WIDTH-1:0] q;
  logic [CHANNELS*WIDTH-1:0] q_n;
  logic [CHANNELS-1:0]       cap;

  modport master (output cp, d, set_n, clr_n, input q, q_n, cap);
  modport slave  (input cp, d, set_n, clr_n, output q, q_n, cap);
endinterface

// File: rtl/hc_dff_bank.sv
// Bank of 74HC74-style D flip-flops clocked by sampled, filtered pin clocks.
module hc_dff_bank #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 0,
  parameter int FILTER      = 0,
  parameter int EDGE_POS    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  hc_dff_bank_if.slave bus
);
  localparam int CNT_W = 4;
  localparam int DW    = CHANNELS * WIDTH;
  // The level the filter rests at after reset equals the active edge's new level,
  // so a pin clock already sitting high (or low) cannot fake an edge on release.
  localparam logic ACT_LVL = (EDGE_POS != 0);

  logic [CHANNELS-1:0] cp_s;
  logic [CHANNELS-1:0] set_n_s;
  logic [CHANNELS-1:0] clr_n_s;
  logic [DW-1:0]       d_s;

  logic [DW-1:0]       q_vec;
  logic [DW-1:0]       q_n_vec;
  logic [CHANNELS-1:0] cap_vec;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign cp_s    = bus.cp;
      assign set_n_s = bus.set_n;
      assign clr_n_s = bus.clr_n;
      assign d_s     = bus.d;
    end else begin : g_sync
      logic [CHANNELS-1:0] cp_sync_reg    [SYNC_STAGES];
      logic [CHANNELS-1:0] set_n_sync_reg [SYNC_STAGES];
      logic [CHANNELS-1:0] clr_n_sync_reg [SYNC_STAGES];
      logic [DW-1:0]       d_sync_reg     [SYNC_STAGES];

      // All four inputs share one chain depth so they stay cycle-aligned.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            cp_sync_reg[i]    <= {CHANNELS{ACT_LVL}};
            set_n_sync_reg[i] <= '1;
            clr_n_sync_reg[i] <= '1;
            d_sync_reg[i]     <= '0;
          end
        end else begin
          cp_sync_reg[0]    <= bus.cp;
          set_n_sync_reg[0] <= bus.set_n;
          clr_n_sync_reg[0] <= bus.clr_n;
          d_sync_reg[0]     <= bus.d;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            cp_sync_reg[i]    <= cp_sync_reg[i-1];
            set_n_sync_reg[i] <= set_n_sync_reg[i-1];
            clr_n_sync_reg[i] <= clr_n_sync_reg[i-1];
            d_sync_reg[i]     <= d_sync_reg[i-1];
          end
        end
      end

      assign cp_s    = cp_sync_reg[SYNC_STAGES-1];
      assign set_n_s = set_n_sync_reg[SYNC_STAGES-1];
      assign clr_n_s = clr_n_sync_reg[SYNC_STAGES-1];
      assign d_s     = d_sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_unit
      logic             filt_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic [WIDTH-1:0] q_reg;
      logic             both_reg;
      logic             cap_reg;
      logic             cp_i;
      logic             set_i;
      logic             clr_i;
      logic [WIDTH-1:0] d_i;
      logic             edge_det;

      assign cp_i  = cp_s[gi];
      assign set_i = ~set_n_s[gi];
      assign clr_i = ~clr_n_s[gi];
      assign d_i   = d_s[gi*WIDTH +: WIDTH];

      // Edge fires on the sample that makes the filtered level flip.
      assign edge_det = (cp_i != filt_reg) && (cnt_reg == CNT_W'(FILTER)) && (cp_i == ACT_LVL);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          filt_reg <= ACT_LVL;
          cnt_reg  <= '0;
          q_reg    <= '0;
          both_reg <= 1'b0;
          cap_reg  <= 1'b0;
        end else begin
          // The filter keeps running under set/clear so a masked edge is consumed.
          if (cp_i == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_W'(FILTER)) begin
            filt_reg <= cp_i;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end

          cap_reg  <= 1'b0;
          both_reg <= set_i && clr_i;
          if (set_i && clr_i) begin
            q_reg <= '1;
          end else if (clr_i) begin
            q_reg <= '0;
          end else if (set_i) begin
            q_reg <= '1;
          end else if (edge_det) begin
            q_reg   <= d_i;
            cap_reg <= 1'b1;
          end
        end
      end

      assign q_vec[gi*WIDTH +: WIDTH]   = q_reg;
      assign q_n_vec[gi*WIDTH +: WIDTH] = both_reg ? {WIDTH{1'b1}} : ~q_reg;
      assign cap_vec[gi]                = cap_reg;
    end
  endgenerate

  assign bus.q   = q_vec;
  assign bus.q_n = q_n_vec;
  assign bus.cap = cap_vec;
endmodule

// File: tb/tb_hc_dff_bank.sv
// Scoreboard bench for hc_dff_bank: three parameterisations, directed vectors.
module tb_hc_dff_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // a: defaults; b: 2 sync stages, filter 3, 8-bit; c: falling edge, 2x2 bits
  hc_dff_bank_if #(.CHANNELS(2), .WIDTH(1)) if_a ();
  hc_dff_bank_if #(.CHANNELS(1), .WIDTH(8)) if_b ();
  hc_dff_bank_if #(.CHANNELS(2), .WIDTH(2)) if_c ();

  hc_dff_bank #(.CHANNELS(2), .WIDTH(1), .SYNC_STAGES(0), .FILTER(0), .EDGE_POS(1))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  hc_dff_bank #(.CHANNELS(1), .WIDTH(8), .SYNC_STAGES(2), .FILTER(3), .EDGE_POS(1))
    u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  hc_dff_bank #(.CHANNELS(2), .WIDTH(2), .SYNC_STAGES(0), .FILTER(0), .EDGE_POS(0))
    u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  logic [15:0] mq   [3];
  logic [15:0] mqn  [3];
  logic [15:0] mcap [3];
  assign mq[0]   = 16'(if_a.q);
  assign mq[1]   = 16'(if_b.q);
  assign mq[2]   = 16'(if_c.q);
  assign mqn[0]  = 16'(if_a.q_n);
  assign mqn[1]  = 16'(if_b.q_n);
  assign mqn[2]  = 16'(if_c.q_n);
  assign mcap[0] = 16'(if_a.cap);
  assign mcap[1] = 16'(if_b.cap);
  assign mcap[2] = 16'(if_c.cap);

  typedef struct {
    int          due;
    int          dut;
    logic [15:0] q;
    logic [15:0] qn;
    logic [15:0] cap;
    string       name;
  } exp_t;

  typedef struct {
    int          dut;
    logic [15:0] cap;
    logic [15:0] q;
    string       name;
  } cap_t;

  exp_t sched[$];
  cap_t capq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic expect_at(input int dut, input int dly, input logic [15:0] q,
                           input logic [15:0] qn, input logic [15:0] cap, input string name);
    exp_t e;
    e.due = cyc + dly; e.dut = dut; e.q = q; e.qn = qn; e.cap = cap; e.name = name;
    sched.push_back(e);
  endtask

  task automatic expect_cap(input int dut, input logic [15:0] cap, input logic [15:0] q,
                            input string name);
    cap_t c;
    c.dut = dut; c.cap = cap; c.q = q; c.name = name;
    capq.push_back(c);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: scheduled level checks plus a pop on every capture pulse.
  always @(negedge clk) begin
    int idx;
    for (int i = sched.size() - 1; i >= 0; i--) begin
      if (sched[i].due <= cyc) begin
        vectors++;
        if (mq[sched[i].dut] !== sched[i].q || mqn[sched[i].dut] !== sched[i].qn ||
            mcap[sched[i].dut] !== sched[i].cap) begin
          miscompares++;
          $display("FAIL %s (dut %0d, cyc %0d): got q=%h q_n=%h cap=%h, required q=%h q_n=%h cap=%h",
                   sched[i].name, sched[i].dut, cyc, mq[sched[i].dut], mqn[sched[i].dut],
                   mcap[sched[i].dut], sched[i].q, sched[i].qn, sched[i].cap);
        end else begin
          $display("ok   %s (dut %0d, cyc %0d) q=%h q_n=%h cap=%h", sched[i].name, sched[i].dut,
                   cyc, mq[sched[i].dut], mqn[sched[i].dut], mcap[sched[i].dut]);
        end
        sched.delete(i);
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (mcap[k] != 16'h0) begin
        idx = -1;
        for (int j = 0; j < capq.size(); j++)
          if (idx < 0 && capq[j].dut == k) idx = j;
        vectors++;
        if (idx < 0) begin
          miscompares++;
          $display("FAIL unexpected_capture (dut %0d, cyc %0d): got cap=%h q=%h, required no capture",
                   k, cyc, mcap[k], mq[k]);
        end else begin
          if (mcap[k] !== capq[idx].cap || mq[k] !== capq[idx].q) begin
            miscompares++;
            $display("FAIL %s_capture (dut %0d, cyc %0d): got cap=%h q=%h, required cap=%h q=%h",
                     capq[idx].name, k, cyc, mcap[k], mq[k], capq[idx].cap, capq[idx].q);
          end else begin
            $display("ok   %s_capture (dut %0d, cyc %0d) cap=%h q=%h", capq[idx].name, k, cyc,
                     mcap[k], mq[k]);
          end
          capq.delete(idx);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    if_a.cp = 2'b00; if_a.d = 2'b00; if_a.set_n = 2'b11; if_a.clr_n = 2'b11;
    if_b.cp = 1'b0;  if_b.d = 8'h00; if_b.set_n = 1'b1;  if_b.clr_n = 1'b1;
    if_c.cp = 2'b11; if_c.d = 4'h0;  if_c.set_n = 2'b11; if_c.clr_n = 2'b11;

    step(2);
    expect_at(0, 1, 16'h0, 16'h3,  16'h0, "rst_a");
    expect_at(1, 1, 16'h0, 16'hFF, 16'h0, "rst_b");
    expect_at(2, 1, 16'h0, 16'hF,  16'h0, "rst_c");
    step(2);
    rst_n = 1'b1;
    step(10);

    // Basic rising-edge capture on each unit of a
    if_a.d = 2'b01; if_a.cp = 2'b01;
    expect_at(0, 1, 16'h1, 16'h2, 16'h1, "r28_cap");
    expect_cap(0, 16'h1, 16'h1, "r28");
    expect_at(0, 2, 16'h1, 16'h2, 16'h0, "r28_pulse");
    step(2);
    if_a.cp = 2'b00;
    step(2);
    if_a.d = 2'b10; if_a.cp = 2'b10;
    expect_at(0, 1, 16'h3, 16'h0, 16'h2, "unit1_cap");
    expect_cap(0, 16'h2, 16'h3, "unit1");
    step(2);
    if_a.cp = 2'b00; if_a.d = 2'b00;
    step(2);

    // Preset/clear on unit 0, including the illegal both-asserted state
    if_a.set_n = 2'b10; if_a.clr_n = 2'b10;
    expect_at(0, 1, 16'h3, 16'h1, 16'h0, "r30_both");
    step(2);
    if_a.clr_n = 2'b11;
    expect_at(0, 1, 16'h3, 16'h0, 16'h0, "r30_set");
    step(2);
    if_a.set_n = 2'b11; if_a.clr_n = 2'b10;
    expect_at(0, 1, 16'h2, 16'h1, 16'h0, "r30_clr");
    step(2);
    if_a.clr_n = 2'b11;
    step(2);

    // Edge masked by clear, not replayed on release
    if_a.d = 2'b01; if_a.cp = 2'b01; if_a.clr_n = 2'b10;
    expect_at(0, 1, 16'h2, 16'h1, 16'h0, "r32_clr");
    step(2);
    if_a.clr_n = 2'b11;
    expect_at(0, 1, 16'h2, 16'h1, 16'h0, "r32_release");
    expect_at(0, 3, 16'h2, 16'h1, 16'h0, "r32_hold");
    step(4);
    if_a.cp = 2'b00;
    step(2);
    if_a.cp = 2'b01;
    expect_at(0, 1, 16'h3, 16'h0, 16'h1, "r32_fresh");
    expect_cap(0, 16'h1, 16'h3, "r32_fresh");
    step(3);

    // Synchroniser + filter latency, glitch rejection, minimum accepted pulse
    if_b.d = 8'hA5; if_b.cp = 1'b1;
    expect_at(1, 5, 16'h00, 16'hFF, 16'h0, "r29_early");
    expect_at(1, 6, 16'hA5, 16'h5A, 16'h1, "r29_cap");
    expect_cap(1, 16'h1, 16'hA5, "r29");
    expect_at(1, 7, 16'hA5, 16'h5A, 16'h0, "r29_pulse");
    step(8);
    if_b.cp = 1'b0;
    step(10);
    if_b.d = 8'h3C; if_b.cp = 1'b1;
    step(3);
    if_b.cp = 1'b0;
    expect_at(1, 7, 16'hA5, 16'h5A, 16'h0, "r29_glitch");
    step(10);
    if_b.cp = 1'b1;
    expect_at(1, 6, 16'h3C, 16'hC3, 16'h1, "r29_4clk");
    expect_cap(1, 16'h1, 16'h3C, "r29_4clk");
    step(4);
    if_b.cp = 1'b0;
    step(10);

    // Falling-edge variant
    if_c.d = 4'b0011; if_c.cp = 2'b10;
    expect_at(2, 1, 16'h3, 16'hC, 16'h1, "r31_fall");
    expect_cap(2, 16'h1, 16'h3, "r31");
    step(3);
    if_c.d = 4'b0000; if_c.cp = 2'b11;
    expect_at(2, 1, 16'h3, 16'hC, 16'h0, "r31_rise");
    step(3);

    // Reset mid-filter-count with cp held high
    if_b.d = 8'h5A; if_b.cp = 1'b1;
    step(3);
    rst_n = 1'b0;
    expect_at(1, 1, 16'h00, 16'hFF, 16'h0, "r33_rst");
    step(2);
    rst_n = 1'b1;
    expect_at(1, 12, 16'h00, 16'hFF, 16'h0, "r33_hold");
    step(14);
    if_b.cp = 1'b0;
    step(10);
    if_b.cp = 1'b1;
    expect_at(1, 6, 16'h5A, 16'hA5, 16'h1, "r33_recap");
    expect_cap(1, 16'h1, 16'h5A, "r33_recap");
    step(10);

    step(5);
    foreach (sched[i]) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_unchecked (dut %0d): got no check by cyc %0d, required check at cyc %0d",
               sched[i].name, sched[i].dut, cyc, sched[i].due);
    end
    foreach (capq[i]) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_missing (dut %0d): got no capture, required cap=%h q=%h",
               capq[i].name, capq[i].dut, capq[i].cap, capq[i].q);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
